// File: rtl/ysyx_24080006_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Operation encoding, decoder control bundle, FSM states and iteration count.
package ysyx_24080006_pkg;

    localparam int XLEN     = 32;
    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MULL = 2'd0,
        MULH = 2'd1,
        DIV  = 2'd2,
        REM  = 2'd3
    } mdu_op_e;

    typedef struct packed {
        logic    mdu_enable;
        logic    signed_a;
        logic    signed_b;
        mdu_op_e mdu_op;
    } mdu_set_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_e;

    // Division-class operations share the restoring divider and special cases
    function automatic logic isDivOp(input mdu_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_ctrl_if.sv
// Request/response bundle between the execute stage and the MDU sequencer.
// master = pipeline side issuing operations, slave = the sequencer itself.
interface ysyx_24080006_mdu_ctrl_if;
    import ysyx_24080006_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    mdu_set_t        mdu_set;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, mdu_set, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, mdu_set, src_a, src_b, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/ysyx_24080006_mdu_iter.sv
// One combinational step of the iterative datapath.
// Multiply: radix-2 shift-add, multiplier starts in acc[31:0], product ends in acc[63:0].
// Divide: restoring division, dividend starts in acc[31:0]; quotient ends in
// acc[31:0] and remainder in acc[63:32]. Bit 64 is headroom and always stays 0.
module ysyx_24080006_mdu_iter
    import ysyx_24080006_pkg::*;
(
    input  logic              isDiv_i,
    input  logic [2*XLEN:0]   acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN:0]   acc_o
);

    logic [XLEN:0]   addSum;
    logic [2*XLEN:0] shifted;
    logic [XLEN:0]   trial;
    logic            unusedTop;

    assign unusedTop = acc_i[2*XLEN];

    // Compute both step flavours and keep the one selected by the operation class
    always_comb begin
        addSum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        shifted = {acc_i[2*XLEN-1:0], 1'b0};
        trial   = shifted[2*XLEN:XLEN] - {1'b0, opnd_i};
        acc_o   = '0;
        if (isDiv_i) begin
            if (shifted[2*XLEN:XLEN] >= {1'b0, opnd_i}) begin
                acc_o = {trial, shifted[XLEN-1:1], 1'b1};
            end else begin
                acc_o = shifted;
            end
        end else begin
            acc_o = {1'b0, addSum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// Iterative RV32M multiply/divide sequencer sitting beside the ALU.
// Operands are converted to magnitudes at accept, iterated 32 times (or
// resolved immediately for divide-by-zero / signed overflow), sign-corrected
// in FIXUP and presented in DONE until the consumer takes the result.
// Optional macro YSYX_24080006_MDU_FAST_MUL_EN: multiplies finish in a single
// CALC cycle using one 32x32 multiplier; division is unaffected.
module ysyx_24080006_mdu_ctrl
    import ysyx_24080006_pkg::*;
(
    input logic                      clock,
    input logic                      reset,
    ysyx_24080006_mdu_ctrl_if.slave  bus
);

    mdu_state_e      state_q;
    logic [4:0]      cnt_q;
    logic [2*XLEN:0] acc_q;
    logic [XLEN-1:0] opnd_q;
    mdu_op_e         op_q;
    logic            negA_q;
    logic            negB_q;
    logic [XLEN-1:0] result_q;
    logic            outValid_q;

    logic [2*XLEN:0] accStep_d;
    logic [XLEN-1:0] fixResult_d;
    logic [XLEN-1:0] specResult_d;
    logic            special_d;
    logic            reqIsDiv_d;
    logic            negA_d;
    logic            negB_d;
    logic [XLEN-1:0] magA_d;
    logic [XLEN-1:0] magB_d;
    logic [2*XLEN-1:0] prodSigned_d;
    logic            unusedEnable;

`ifdef YSYX_24080006_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fastProd_d;
    assign fastProd_d = {{XLEN{1'b0}}, opnd_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
`endif

    assign unusedEnable = bus.mdu_set.mdu_enable;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = outValid_q;
    assign bus.result    = result_q;

    ysyx_24080006_mdu_iter u_iter (
        .isDiv_i (isDivOp(op_q)),
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .acc_o   (accStep_d)
    );

    // Request decode: operand signs, magnitudes and the no-iteration division cases
    always_comb begin
        reqIsDiv_d   = isDivOp(bus.mdu_set.mdu_op);
        negA_d       = bus.mdu_set.signed_a && bus.src_a[XLEN-1];
        negB_d       = (reqIsDiv_d ? bus.mdu_set.signed_a : bus.mdu_set.signed_b) && bus.src_b[XLEN-1];
        magA_d       = negA_d ? ({XLEN{1'b0}} - bus.src_a) : bus.src_a;
        magB_d       = negB_d ? ({XLEN{1'b0}} - bus.src_b) : bus.src_b;
        special_d    = 1'b0;
        specResult_d = '0;
        if (reqIsDiv_d && (bus.src_b == '0)) begin
            special_d    = 1'b1;
            specResult_d = (bus.mdu_set.mdu_op == DIV) ? {XLEN{1'b1}} : bus.src_a;
        end else if (reqIsDiv_d && bus.mdu_set.signed_a &&
                     (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b == {XLEN{1'b1}})) begin
            special_d    = 1'b1;
            specResult_d = (bus.mdu_set.mdu_op == DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
        end
    end

    // Sign correction and result selection from the finished accumulator
    always_comb begin
        prodSigned_d = (negA_q ^ negB_q) ? ({(2*XLEN){1'b0}} - acc_q[2*XLEN-1:0]) : acc_q[2*XLEN-1:0];
        fixResult_d  = '0;
        case (op_q)
            MULL:    fixResult_d = prodSigned_d[XLEN-1:0];
            MULH:    fixResult_d = prodSigned_d[2*XLEN-1:XLEN];
            DIV:     fixResult_d = (negA_q ^ negB_q) ? ({XLEN{1'b0}} - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
            REM:     fixResult_d = negA_q ? ({XLEN{1'b0}} - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
            default: fixResult_d = '0;
        endcase
    end

    // Sequencer FSM: accept, iterate, fix up, then hold the result until taken
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            op_q       <= MULL;
            negA_q     <= 1'b0;
            negB_q     <= 1'b0;
            result_q   <= '0;
            outValid_q <= 1'b0;
        end else if (bus.flush) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q   <= bus.mdu_set.mdu_op;
                        negA_q <= negA_d;
                        negB_q <= negB_d;
                        cnt_q  <= '0;
                        if (reqIsDiv_d) begin
                            opnd_q <= magB_d;
                            acc_q  <= {{(XLEN+1){1'b0}}, magA_d};
                        end else begin
                            opnd_q <= magA_d;
                            acc_q  <= {{(XLEN+1){1'b0}}, magB_d};
                        end
                        if (special_d) begin
                            result_q   <= specResult_d;
                            outValid_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
`ifdef YSYX_24080006_MDU_FAST_MUL_EN
                    if (!isDivOp(op_q)) begin
                        acc_q   <= {1'b0, fastProd_d};
                        state_q <= FIXUP;
                    end else begin
                        acc_q <= accStep_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(MDU_ITER - 1)) begin
                            state_q <= FIXUP;
                        end
                    end
`else
                    acc_q <= accStep_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(MDU_ITER - 1)) begin
                        state_q <= FIXUP;
                    end
`endif
                end
                FIXUP: begin
                    result_q   <= fixResult_d;
                    outValid_q <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// Self-checking bench for the MDU sequencer: directed vector table, randomized
// operations against an arithmetic reference model, and handshake/abort sequences.
// Latency is counted in clock edges with the accept edge itself as edge 1.
module tb_ysyx_24080006_mdu_ctrl;
    import ysyx_24080006_pkg::*;

    localparam int LAT_LIMIT = 100;
`ifdef YSYX_24080006_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT  = 34;
    localparam int SPEC_LAT = 1;

    typedef struct packed {
        mdu_op_e     op;
        logic        signedA;
        logic        signedB;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
        int          expLatency;
    } vector_t;

    logic    clock = 1'b0;
    logic    reset;
    int      numCompared = 0;
    int      numMismatched = 0;
    vector_t vectors [12];

    ysyx_24080006_mdu_ctrl_if bus ();

    ysyx_24080006_mdu_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Decoder contract: every request carries mdu_enable
    always @(posedge clock) begin
        if (bus.in_valid && !reset) begin
            assert (bus.mdu_set.mdu_enable)
                else $error("[TB] FAIL mduEnable: got 0, expected 1");
        end
    end

    // Architectural result straight from RV32M rules using wide integer arithmetic
    function automatic logic [31:0] refModel(input mdu_op_e op, input logic sa, input logic sb,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ea;
        logic signed [63:0] eb;
        logic signed [63:0] prod;
        logic signed [63:0] quo;
        logic signed [63:0] rem;
        ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
        if (op == MULL || op == MULH) begin
            eb   = sb ? {{32{b[31]}}, b} : {32'b0, b};
            prod = ea * eb;
            return (op == MULL) ? prod[31:0] : prod[63:32];
        end
        eb = sa ? {{32{b[31]}}, b} : {32'b0, b};
        if (b == 32'd0) return (op == DIV) ? 32'hFFFF_FFFF : a;
        if (sa && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == DIV) ? 32'h8000_0000 : 32'd0;
        quo = ea / eb;
        rem = ea % eb;
        return (op == DIV) ? quo[31:0] : rem[31:0];
    endfunction

    function automatic int refLatency(input mdu_op_e op, input logic sa,
                                      input logic [31:0] a, input logic [31:0] b);
        if (op == MULL || op == MULH) return MUL_LAT;
        if (b == 32'd0) return SPEC_LAT;
        if (sa && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPEC_LAT;
        return DIV_LAT;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Present a request and let the accept edge pass
    task automatic startOp(input mdu_op_e op, input logic sa, input logic sb,
                           input logic [31:0] a, input logic [31:0] b);
        bus.mdu_set.mdu_enable = 1'b1;
        bus.mdu_set.signed_a   = sa;
        bus.mdu_set.signed_b   = sb;
        bus.mdu_set.mdu_op     = op;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.in_valid = 1'b1;
        stepCycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < LAT_LIMIT) begin
            stepCycle();
            lat++;
        end
    endtask

    // Full transaction: accept, wait for the result, then take it
    task automatic applyStimulus(input mdu_op_e op, input logic sa, input logic sb,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat);
        startOp(op, sa, sb, a, b);
        waitValid(lat);
        res = bus.result;
        bus.out_ready = 1'b1;
        stepCycle();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic        sawValid;

        vectors[0]  = '{MULL, 1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vectors[1]  = '{MULH, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vectors[2]  = '{MULH, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vectors[3]  = '{MULH, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
        vectors[4]  = '{DIV,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT};
        vectors[5]  = '{REM,  1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT};
        vectors[6]  = '{DIV,  1'b0, 1'b0, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, DIV_LAT};
        vectors[7]  = '{REM,  1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, DIV_LAT};
        vectors[8]  = '{DIV,  1'b1, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPEC_LAT};
        vectors[9]  = '{REM,  1'b0, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPEC_LAT};
        vectors[10] = '{DIV,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT};
        vectors[11] = '{REM,  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC_LAT};

        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mdu_set   = '0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        stepCycle();
        stepCycle();
        reset = 1'b0;

        checkOutput("resetInReady",  bus.in_ready,  1);
        checkOutput("resetOutValid", bus.out_valid, 0);
        checkOutput("resetResult",   bus.result,    0);
        checkOutput("resetBusy",     bus.busy,      0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("vec%0d_inReady", i), bus.in_ready, 1);
            applyStimulus(vectors[i].op, vectors[i].signedA, vectors[i].signedB,
                          vectors[i].a, vectors[i].b, res, lat);
            checkOutput($sformatf("vec%0d_result", i),  res, vectors[i].expResult);
            checkOutput($sformatf("vec%0d_latency", i), lat, vectors[i].expLatency);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            mdu_op_e     op;
            logic        sa;
            logic        sb;
            logic [31:0] a;
            logic [31:0] b;
            op = mdu_op_e'($urandom_range(0, 3));
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            a  = pickOperand();
            b  = pickOperand();
            applyStimulus(op, sa, sb, a, b, res, lat);
            checkOutput($sformatf("rnd%0d_result", i),  res, refModel(op, sa, sb, a, b));
            checkOutput($sformatf("rnd%0d_latency", i), lat, refLatency(op, sa, a, b));
        end

        // Backpressure: result and out_valid hold while the consumer stalls
        startOp(DIV, 1'b0, 1'b0, 32'd100, 32'd7);
        waitValid(lat);
        checkOutput("bpLatency", lat, DIV_LAT);
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            checkOutput($sformatf("bpValid%0d", k),   bus.out_valid, 1);
            checkOutput($sformatf("bpResult%0d", k),  bus.result,    32'd14);
            checkOutput($sformatf("bpInReady%0d", k), bus.in_ready,  0);
        end
        bus.out_ready = 1'b1;
        stepCycle();
        bus.out_ready = 1'b0;
        checkOutput("bpInReadyAfter", bus.in_ready,  1);
        checkOutput("bpValidAfter",   bus.out_valid, 0);
        checkOutput("bpResultHeld",   bus.result,    32'd14);

        // Flush together with in_valid in IDLE must not accept
        bus.mdu_set.mdu_enable = 1'b1;
        bus.mdu_set.signed_a   = 1'b0;
        bus.mdu_set.signed_b   = 1'b0;
        bus.mdu_set.mdu_op     = DIV;
        bus.src_a    = 32'd9;
        bus.src_b    = 32'd3;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        stepCycle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        checkOutput("flushReqBusy", bus.busy, 0);
        stepCycle();
        checkOutput("flushReqBusyLater", bus.busy,      0);
        checkOutput("flushReqValid",     bus.out_valid, 0);

        // Abort in CALC at iteration 10
        startOp(DIV, 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7);
        repeat (10) stepCycle();
        checkOutput("abortBusyBefore", bus.busy, 1);
        bus.flush = 1'b1;
        stepCycle();
        bus.flush = 1'b0;
        checkOutput("abortBusy",    bus.busy,      0);
        checkOutput("abortInReady", bus.in_ready,  1);
        checkOutput("abortValid",   bus.out_valid, 0);
        sawValid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            stepCycle();
            sawValid = sawValid | bus.out_valid;
        end
        checkOutput("abortNoValid", sawValid, 0);
        applyStimulus(MULL, 1'b0, 1'b0, 32'd3, 32'd4, res, lat);
        checkOutput("abortNextResult",  res, 32'd12);
        checkOutput("abortNextLatency", lat, MUL_LAT);

        // Flush in DONE together with out_ready drops the result
        startOp(MULL, 1'b0, 1'b0, 32'd5, 32'd6);
        waitValid(lat);
        checkOutput("doneFlushLatency", lat, MUL_LAT);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        stepCycle();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        checkOutput("doneFlushValid", bus.out_valid, 0);
        checkOutput("doneFlushBusy",  bus.busy,      0);

        // Reset asserted mid-divide behaves like an abort and clears the result
        startOp(DIV, 1'b0, 1'b0, 32'd1000, 32'd3);
        repeat (10) stepCycle();
        checkOutput("resetMidBusyBefore", bus.busy, 1);
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("resetMidBusy",    bus.busy,      0);
        checkOutput("resetMidInReady", bus.in_ready,  1);
        checkOutput("resetMidValid",   bus.out_valid, 0);
        checkOutput("resetMidResult",  bus.result,    0);
        sawValid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            stepCycle();
            sawValid = sawValid | bus.out_valid;
        end
        checkOutput("resetMidNoValid", sawValid, 0);
        applyStimulus(MULL, 1'b0, 1'b0, 32'd3, 32'd4, res, lat);
        checkOutput("resetNextResult",  res, 32'd12);
        checkOutput("resetNextLatency", lat, MUL_LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/ysyx_24080006_mdu_ctrl.md
Name: ysyx_24080006_mdu_ctrl

Overview:
Iterative multiply/divide sequencer for the RV32M operations flagged by the decoder's mdu_set. It sits beside the ALU in the execute stage and accepts one operation through a valid/ready handshake. It runs a radix-2 shift-add multiplier or a restoring divider, and returns a 32-bit result through a second valid/ready handshake. The pipeline can kill an in-flight operation with flush.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
flush  in  1  abort the in-flight or pending operation
in_valid  in  1  operation request
in_ready  out  1  block can accept a request
mdu_set  in  mdu_set_t  {mdu_enable, signed_a, signed_b, mdu_op}
src_a  in  XLEN  rs1 value (multiplicand/dividend)
src_b  in  XLEN  rs2 value (multiplier/divisor)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  XLEN  product low/high, quotient or remainder
busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On reset, state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, and the counter and accumulators are 0.
- Accept rule: a request is accepted on a clock edge where in_valid&&in_ready&&!flush. At accept the block latches the operands, mdu_op, signed_a and signed_b. mdu_enable must be 1 whenever in_valid=1; the bench asserts this and the block ignores the field otherwise.
- in_ready is 1 only in IDLE.
- States:
  - IDLE: on accept, go to DONE if the op is a special case, otherwise go to CALC with cnt=0.
  - CALC: one iteration per cycle, cnt += 1; when cnt==31, go to FIXUP.
  - FIXUP: sign correction and result select; go to DONE.
  - DONE: out_valid=1; on out_ready, go to IDLE.
- Latency: out_valid rises 34 edges after the accept edge (32 CALC + FIXUP + DONE entry). Special cases take 1 edge.
- Sign handling:
  - Operand a is negative if signed_a&&a[31]; operand b is negative if signed_b&&b[31]. The datapath works on magnitudes.
  - MULL/MULH: 64-bit unsigned product, negated if neg_a^neg_b. MULL returns bits[31:0]; MULH returns bits[63:32]. This covers MULH, MULHSU and MULHU.
  - DIV/REM use signed_a for signedness. The quotient is negated if neg_a^neg_b; the remainder takes the sign of the dividend.
- Special cases (no iteration):
  - Division by zero: DIV returns 0xFFFFFFFF; REM returns the dividend.
  - Signed overflow (0x80000000 / -1): DIV returns 0x80000000; REM returns 0.
- Result hold: result and out_valid stay stable while out_valid&&!out_ready. result is held after the handshake until the next DONE.
- Flush: from any state, the next state is IDLE and out_valid=0 on the following edge; the result is discarded. Flush together with in_valid means no accept. Flush in DONE together with out_ready means the result is dropped; the consumer must also ignore it.
- No back-to-back overlap: a new accept happens at the earliest one edge after the DONE handshake.

Optional Feature:
Macro: YSYX_24080006_MDU_FAST_MUL_EN.
- Defined: MULL/MULH compute the 64-bit product in one cycle via a single multiplier in CALC, then go to FIXUP. out_valid rises 3 edges after accept. Division is unchanged.
- Undefined: multiply uses the 32-cycle shift-add path (34-edge latency). No hardware multiplier is inferred.

Decomposition:
- ysyx_24080006_pkg holds:
  - mdu_op_e {MULL, MULH, DIV, REM}
  - mdu_set_t
  - mdu_state_e {IDLE, CALC, FIXUP, DONE}
  - constant MDU_ITER = 32
- A sub-module ysyx_24080006_mdu_iter holds the combinational one-step datapath (shift-add step and restore-subtract step on 64/65-bit accumulators). The FSM, counter, sign fixup and handshakes stay in the top.

Test Plan:
1. MULL: 0x00000007 × 0xFFFFFFFD → 0xFFFFFFEB; out_valid exactly 34 edges after accept (3 with the macro).
2. High products:
   - MULH 0x80000000×0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU (signed_a=1, signed_b=0) 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. Division:
   - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
   - DIVU 7/2 → 3; REMU 0xFFFFFFFF/0x10 → 0xF.
4. Special cases:
   - DIV 5/0 → 0xFFFFFFFF after 1 edge; REMU 5/0 → 5.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0. Raise out_ready → IDLE, then in_ready=1 on the next edge.
6. Abort: flush at CALC cnt=10 → IDLE next edge, out_valid never rises; the following MULL 3×4 returns 12. Reset asserted mid-DIV gives the same response.
